// File: rtl/display_scheduler_if.sv
// Event-in / converter-out bundle of the display scheduler.
// The master side produces note events and watches the converter drive.
// The slave side is the scheduler itself.
interface display_scheduler_if;
   logic       novo_dado;
   logic [4:0] nota;
   logic [7:0] valor;
   logic       select;
   logic [4:0] letra;
   logic [7:0] numero;
   logic       ativo;
   logic [1:0] db_estado;

   modport master (
      output novo_dado, nota, valor,
      input  select, letra, numero, ativo, db_estado
   );

   modport slave (
      input  novo_dado, nota, valor,
      output select, letra, numero, ativo, db_estado
   );
endinterface

// File: rtl/display_scheduler.sv
// Display scheduler: turns detected-note events into letter/number phases
// for the 7-segment converter. Each note is shown for a fixed number of
// letter+number pairs, after which the display blanks.
// Repeating the same note while it is shown keeps the peak value and
// restarts the pair count. A different note restarts the sequence.
module display_scheduler #(
   parameter int         T_LETRA    = 25000000,
   parameter int         T_NUMERO   = 25000000,
   parameter int         REPETICOES = 3,
   parameter logic [4:0] BLANK_CODE = 5'h1F
) (
   input logic               clock,
   input logic               reset_n,
   display_scheduler_if.slave bus
);

   localparam int T_MAX   = (T_LETRA > T_NUMERO) ? T_LETRA : T_NUMERO;
   localparam int DWELL_W = $clog2(T_MAX);
   localparam int REP_W   = (REPETICOES > 1) ? $clog2(REPETICOES) : 1;

   localparam logic [DWELL_W-1:0] LETRA_LAST  = DWELL_W'(T_LETRA - 1);
   localparam logic [DWELL_W-1:0] NUMERO_LAST = DWELL_W'(T_NUMERO - 1);
   localparam logic [REP_W-1:0]   REP_LAST    = REP_W'(REPETICOES - 1);

   typedef enum logic [1:0] {
      IDLE        = 2'b00,
      SHOW_LETRA  = 2'b01,
      SHOW_NUMERO = 2'b10
   } state_t;

   state_t             state_q, state_d;
   logic               select_q, select_d;
   logic [4:0]         letra_q, letra_d;
   logic [7:0]         numero_q, numero_d;
   logic               ativo_q, ativo_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [REP_W-1:0]   rep_q, rep_d;

   logic event_valid;
   logic showing;
   logic same_note;
   logic new_note;

   // Next-state logic: phase timing first, then incoming events override it
   // (a same-note event turns a final expiry into another letter phase).
   always_comb begin
      state_d  = state_q;
      select_d = select_q;
      letra_d  = letra_q;
      numero_d = numero_q;
      ativo_d  = ativo_q;
      dwell_d  = dwell_q;
      rep_d    = rep_q;

      event_valid = bus.novo_dado && (bus.nota != BLANK_CODE);
      showing     = (state_q == SHOW_LETRA) || (state_q == SHOW_NUMERO);
      same_note   = event_valid && showing && (bus.nota == letra_q);
      new_note    = event_valid && !same_note;

      case (state_q)
         IDLE: begin
         end
         SHOW_LETRA: begin
            if (dwell_q == LETRA_LAST) begin
               state_d  = SHOW_NUMERO;
               select_d = 1'b0;
               dwell_d  = '0;
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end
         SHOW_NUMERO: begin
            if (dwell_q == NUMERO_LAST) begin
               dwell_d = '0;
               if ((rep_q == REP_LAST) && !same_note) begin
                  state_d  = IDLE;
                  select_d = 1'b1;
                  letra_d  = BLANK_CODE;
                  ativo_d  = 1'b0;
                  rep_d    = '0;
               end else begin
                  state_d  = SHOW_LETRA;
                  select_d = 1'b1;
                  rep_d    = rep_q + 1'b1;
               end
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end
         default: begin
            state_d  = IDLE;
            select_d = 1'b1;
            letra_d  = BLANK_CODE;
            ativo_d  = 1'b0;
            dwell_d  = '0;
            rep_d    = '0;
         end
      endcase

      if (same_note) begin
         rep_d = '0;
         if (bus.valor > numero_q) begin
            numero_d = bus.valor;
         end
      end

      if (new_note) begin
         state_d  = SHOW_LETRA;
         select_d = 1'b1;
         letra_d  = bus.nota;
         numero_d = bus.valor;
         ativo_d  = 1'b1;
         dwell_d  = '0;
         rep_d    = '0;
      end
   end

   // State and output registers; reset blanks the display and aborts any sequence.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         select_q <= 1'b1;
         letra_q  <= BLANK_CODE;
         numero_q <= 8'd0;
         ativo_q  <= 1'b0;
         dwell_q  <= '0;
         rep_q    <= '0;
      end else begin
         state_q  <= state_d;
         select_q <= select_d;
         letra_q  <= letra_d;
         numero_q <= numero_d;
         ativo_q  <= ativo_d;
         dwell_q  <= dwell_d;
         rep_q    <= rep_d;
      end
   end

   assign bus.select    = select_q;
   assign bus.letra     = letra_q;
   assign bus.numero    = numero_q;
   assign bus.ativo     = ativo_q;
   assign bus.db_estado = state_q;

endmodule
